cla_pipe_adder16: RTL and testbench
===================================

CLA_PIPE_ADDER16 -- requirements
Module: cla_pipe_adder16

Interface
REQ-001 SHALL have parameter: none; width fixed at 16 bits (4 nibble slices).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  upstream operand set valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operand set this cycle.
REQ-006 SHALL have port: a  input  16  operand A.
REQ-007 SHALL have port: b  input  16  operand B.
REQ-008 SHALL have port: cin  input  1  carry-in.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port: sum  output  16  a + b + cin, modulo 2^16.
REQ-012 SHALL have port: cout  output  1  carry out of bit 15.
REQ-013 SHALL have port: ovf  output  1  signed overflow: a[15]==b[15] and sum[15]!=a[15].

Function
REQ-014 SHALL implement a 4-stage pipeline; stage k (1..4) adds nibble k-1 of a/b with the carry from stage k-1 (stage 1 uses cin) using one 4-bit carry-lookahead slice.
REQ-015 Each stage register SHALL hold: valid bit, completed low sum nibbles, carry, still-unadded upper nibbles of a and b, and a[15]/b[15] for ovf.
REQ-016 Input transfer SHALL occur on an edge where in_valid && in_ready; output transfer where out_valid && out_ready.
REQ-017 Global advance enable SHALL be en = !out_valid || out_ready; all four stages shift together when en=1 and hold when en=0.
REQ-018 in_ready SHALL equal en (combinational, no dependency on in_valid).
REQ-019 Latency: operand accepted at edge k SHALL appear on outputs with out_valid=1 after edge k+3; throughput one result per cycle when out_ready held high.
REQ-020 When en=1 and no input transfer, a bubble (valid=0) SHALL enter stage 1.
REQ-021 sum, cout, ovf SHALL be registered outputs of stage 4 and SHALL remain stable while out_valid && !out_ready.
REQ-022 Results SHALL emerge in acceptance order; none dropped or duplicated under any in_valid/out_ready pattern.
REQ-023 Simultaneous input and output transfer in the same cycle SHALL be supported with no bubble inserted.
REQ-024 Carry wrap: a=16'hFFFF, b=16'h0000, cin=1 SHALL yield sum=16'h0000, cout=1 (full ripple through all stages).
REQ-025 out_valid SHALL never assert for a bubble; sum/cout/ovf values under out_valid=0 are don't-care.

Reset
REQ-026 On rst=1 at a rising edge, all stage valid bits SHALL clear; out_valid=0, sum=16'h0000, cout=0, ovf=0 after that edge.
REQ-027 Reset mid-operation SHALL discard all in-flight operands; no result from before reset SHALL appear afterwards.
REQ-028 During rst=1, in_ready SHALL read 1 (en=1 since out_valid=0) but no transfer is recorded.

Structure
REQ-029 Shared package SHALL define: NIB_W=4, NUM_STAGES=4, DATA_W=16, and the stage-register struct type.
REQ-030 SHALL instantiate sub-module cla4_slice (4-bit carry-lookahead adder, ports a[3:0], b[3:0], ci, s[3:0], co) once per stage; pure combinational.
REQ-031 No combinational path from in_valid to in_ready, or from a/b to any output.

Verification
REQ-032 Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0, ovf=0; no result appears 8 cycles after release with in_valid=0.
REQ-033 Single op: a=16'h1234, b=16'h4321, cin=0, out_ready=1 -> after edge k+3: sum=16'h5555, cout=0, ovf=0.
REQ-034 Ripple/overflow: a=16'hFFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0; a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
REQ-035 Back-to-back: 16 random operand sets on consecutive cycles, out_ready=1 -> 16 consecutive out_valid cycles, each sum matching a reference model in order.
REQ-036 Backpressure: stream 10 ops, out_ready random 50% -> in_ready tracks en, outputs stable while stalled, all 10 results correct and in order.
REQ-037 Reset mid-flight: accept 3 ops, assert rst after 2nd edge -> none of the 3 results ever asserts out_valid.

Source files
------------

// File: rtl/cla_pipe_adder16_pkg.sv
// Shared widths and the pipeline stage register layout for the 16-bit
// pipelined carry-lookahead adder.
package cla_pipe_adder16_pkg;

  localparam int NIB_W      = 4;
  localparam int NUM_STAGES = 4;
  localparam int DATA_W     = 16;

  // One pipeline stage register.
  // sum   : nibbles already added are valid; higher nibbles are zero/ignored.
  // carry : carry out of the most recently added nibble.
  // a, b  : operands; only the nibbles not yet added are consumed downstream.
  // a_msb, b_msb : operand sign bits, kept for the overflow flag at the end.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] sum;
    logic              carry;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              a_msb;
    logic              b_msb;
  } stage_t;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice, purely combinational.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Generate/propagate terms and flattened lookahead carries.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c[3:0];
    co   = c[4];
  end

endmodule

// File: rtl/cla_pipe_adder16.sv
// 16-bit adder pipelined one nibble per stage, four stages, with a single
// global advance enable for valid/ready flow control.
//
// Handshake: a transfer happens on a rising edge where valid && ready is seen
// on that interface. Every stage shifts together when en = !out_valid ||
// out_ready; in_ready equals en and never looks at in_valid. The outputs are
// the stage-4 register and therefore hold still while out_valid && !out_ready.
module cla_pipe_adder16
  import cla_pipe_adder16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  stage_t st  [NUM_STAGES];
  stage_t nxt [NUM_STAGES];

  logic [NIB_W-1:0] sl_a  [NUM_STAGES];
  logic [NIB_W-1:0] sl_b  [NUM_STAGES];
  logic [NIB_W-1:0] sl_s  [NUM_STAGES];
  logic             sl_ci [NUM_STAGES];
  logic             sl_co [NUM_STAGES];

  logic en;

  assign en       = !st[NUM_STAGES-1].valid || out_ready;
  assign in_ready = en;

  // Slice operands: stage 1 adds nibble 0 straight from the inputs, later
  // stages add their own nibble from the previous stage register.
  always_comb begin
    sl_a[0]  = a[NIB_W-1:0];
    sl_b[0]  = b[NIB_W-1:0];
    sl_ci[0] = cin;
    for (int i = 1; i < NUM_STAGES; i++) begin
      sl_a[i]  = st[i-1].a[i*NIB_W +: NIB_W];
      sl_b[i]  = st[i-1].b[i*NIB_W +: NIB_W];
      sl_ci[i] = st[i-1].carry;
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_slice
    cla4_slice u_slice (
      .a  (sl_a[g]),
      .b  (sl_b[g]),
      .ci (sl_ci[g]),
      .s  (sl_s[g]),
      .co (sl_co[g])
    );
  end

  // Next contents of each stage: the incoming entry with one more nibble
  // of sum filled in. A non-transfer cycle loads a bubble (valid=0).
  always_comb begin
    nxt[0]       = '0;
    nxt[0].valid = in_valid;
    nxt[0].sum   = {{(DATA_W-NIB_W){1'b0}}, sl_s[0]};
    nxt[0].carry = sl_co[0];
    nxt[0].a     = a;
    nxt[0].b     = b;
    nxt[0].a_msb = a[DATA_W-1];
    nxt[0].b_msb = b[DATA_W-1];
    for (int i = 1; i < NUM_STAGES; i++) begin
      nxt[i]                        = st[i-1];
      nxt[i].sum[i*NIB_W +: NIB_W]  = sl_s[i];
      nxt[i].carry                  = sl_co[i];
    end
  end

  // Stage registers: cleared on reset, shift together when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) st[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < NUM_STAGES; i++) st[i] <= nxt[i];
    end
  end

  assign out_valid = st[NUM_STAGES-1].valid;
  assign sum       = st[NUM_STAGES-1].sum;
  assign cout      = st[NUM_STAGES-1].carry;
  assign ovf       = (st[NUM_STAGES-1].a_msb == st[NUM_STAGES-1].b_msb) &&
                     (st[NUM_STAGES-1].sum[DATA_W-1] != st[NUM_STAGES-1].a_msb);

endmodule

// File: tb/tb_cla_pipe_adder16.sv
// Self-checking bench for cla_pipe_adder16: arithmetic reference model with
// an expected queue, a negedge compare process, and directed vectors.
module tb_cla_pipe_adder16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_c;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  // expected entries: {ovf, cout, sum}
  logic [17:0] exp_q[$];

  logic        prev_stall = 1'b0;
  logic [15:0] prev_sum;
  logic        prev_cout;
  logic        prev_ovf;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  cla_pipe_adder16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (op_a),
    .b         (op_b),
    .cin       (op_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // ---------------- model ----------------
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    logic [16:0] t;
    logic        v;
    t = {1'b0, x} + {1'b0, y} + {16'd0, c};
    v = (x[15] == y[15]) && (t[15] != x[15]);
    return {v, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", sum, prev_sum);
        chk("hold_cout", cout, prev_cout);
        chk("hold_ovf", ovf, prev_ovf);
      end
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sum", sum, e[15:0]);
          chk("cout", cout, e[16]);
          chk("ovf", ovf, e[17]);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_cout  = cout;
      prev_ovf   = ovf;
      if (in_valid && in_ready) exp_q.push_back(model(op_a, op_b, op_c));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic single(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input string tag);
    @(posedge clk); #1;
    out_ready = 1'b1;
    op_a = xa; op_b = xb; op_c = xc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_early1"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_early2"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
  endtask

  task automatic check_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk(tag, out_valid, 0);
    end
  endtask

  task automatic back_to_back();
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      op_a = 16'($urandom_range(0, 65535));
      op_b = 16'($urandom_range(0, 65535));
      op_c = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (i >= 3) chk("b2b_stream", out_valid, 1);
    end
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      chk("b2b_tail", out_valid, 1);
    end
    @(posedge clk); #1;
    chk("b2b_end", out_valid, 0);
  endtask

  task automatic backpressure();
    logic done;
    for (int i = 0; i < 10; i++) begin
      done = 1'b0;
      for (int t = 0; t < 50 && !done; t++) begin
        @(posedge clk); #1;
        op_a = 16'($urandom_range(0, 65535));
        op_b = 16'($urandom_range(0, 65535));
        op_c = 1'($urandom_range(0, 1));
        in_valid  = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        #1;
        done = in_ready;
      end
      chk("bp_accept_timeout", done, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    chk("bp_drained", exp_q.size(), 0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_mid_flight();
    @(posedge clk); #1;
    out_ready = 1'b1;
    op_a = 16'h1111; op_b = 16'h2222; op_c = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    op_a = 16'h3333; op_b = 16'h4444;
    @(posedge clk); #1;
    op_a = 16'h5555; op_b = 16'h6666;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rmf_out_valid", out_valid, 0);
    check_idle(8, "rmf_idle");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    op_a = 16'hABCD; op_b = 16'h1234; op_c = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_in_ready", in_ready, 1);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    check_idle(8, "post_rst_idle");

    single(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "basic");
    single(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "ripple");
    single(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
    single(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");
    single(16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0, "mid_carry");

    back_to_back();
    backpressure();
    reset_mid_flight();

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
